// File: rtl/ecc_err_log_if.sv
// ---------------------------------------------------------------------------
// ecc_err_log_if
// Purpose : bundles the decoder-side inputs, host controls and logging
//           outputs of ecc_err_log into one interface.
// Modports: slave  - the logger itself (consumes decoder/host inputs,
//                    drives counters, captures, interrupt)
//           master - whoever drives the logger (decoder + host)
// Signals : clkena_i, rd_valid_i, rd_addr_i, syndrome_i, sb_err_i, db_err_i,
//           sb_fix_i, thresh_i, clr_i, irq_ack_i              (to logger)
//           sb_cnt_o, db_cnt_o, sb_vld_o, sb_addr_o, sb_syn_o,
//           db_vld_o, db_addr_o, db_syn_o, irq_o              (from logger)
// Option  : ECC_ERR_LOG_SCRUB_EN adds scrub_req_o, scrub_addr_o, scrub_ack_i.
// ---------------------------------------------------------------------------
interface ecc_err_log_if #(
    parameter int ADDR_W = 32,
    parameter int SYN_W  = 5,
    parameter int CNT_W  = 16
);
    logic              clkena_i;
    logic              rd_valid_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [SYN_W-1:0]  syndrome_i;
    logic              sb_err_i;
    logic              db_err_i;
    logic              sb_fix_i;
    logic [CNT_W-1:0]  thresh_i;
    logic              clr_i;
    logic              irq_ack_i;

    logic [CNT_W-1:0]  sb_cnt_o;
    logic [CNT_W-1:0]  db_cnt_o;
    logic              sb_vld_o;
    logic [ADDR_W-1:0] sb_addr_o;
    logic [SYN_W-1:0]  sb_syn_o;
    logic              db_vld_o;
    logic [ADDR_W-1:0] db_addr_o;
    logic [SYN_W-1:0]  db_syn_o;
    logic              irq_o;

`ifdef ECC_ERR_LOG_SCRUB_EN
    logic              scrub_req_o;
    logic [ADDR_W-1:0] scrub_addr_o;
    logic              scrub_ack_i;

    modport slave (
        input  clkena_i, rd_valid_i, rd_addr_i, syndrome_i, sb_err_i,
               db_err_i, sb_fix_i, thresh_i, clr_i, irq_ack_i, scrub_ack_i,
        output sb_cnt_o, db_cnt_o, sb_vld_o, sb_addr_o, sb_syn_o,
               db_vld_o, db_addr_o, db_syn_o, irq_o, scrub_req_o, scrub_addr_o
    );

    modport master (
        output clkena_i, rd_valid_i, rd_addr_i, syndrome_i, sb_err_i,
               db_err_i, sb_fix_i, thresh_i, clr_i, irq_ack_i, scrub_ack_i,
        input  sb_cnt_o, db_cnt_o, sb_vld_o, sb_addr_o, sb_syn_o,
               db_vld_o, db_addr_o, db_syn_o, irq_o, scrub_req_o, scrub_addr_o
    );
`else
    modport slave (
        input  clkena_i, rd_valid_i, rd_addr_i, syndrome_i, sb_err_i,
               db_err_i, sb_fix_i, thresh_i, clr_i, irq_ack_i,
        output sb_cnt_o, db_cnt_o, sb_vld_o, sb_addr_o, sb_syn_o,
               db_vld_o, db_addr_o, db_syn_o, irq_o
    );

    modport master (
        output clkena_i, rd_valid_i, rd_addr_i, syndrome_i, sb_err_i,
               db_err_i, sb_fix_i, thresh_i, clr_i, irq_ack_i,
        input  sb_cnt_o, db_cnt_o, sb_vld_o, sb_addr_o, sb_syn_o,
               db_vld_o, db_addr_o, db_syn_o, irq_o
    );
`endif
endinterface

// File: rtl/ecc_err_log.sv
// ---------------------------------------------------------------------------
// ecc_err_log
// Purpose : error logger placed right after the extended-Hamming decoder.
//           Delays each read's valid/address by the decoder latency so they
//           line up with the decoder flags, counts single- and double-bit
//           errors (saturating), captures the first failing address and
//           syndrome of each class and raises an acknowledgeable interrupt.
// Ports   : clk_i  - clock, rising edge
//           rst_ni - asynchronous active-low reset
//           bus    - ecc_err_log_if.slave (decoder flags, host controls,
//                    counters, captures, irq_o)
// Params  : ADDR_W, SYN_W, CNT_W, LATENCY (decoder latency 0..2)
// Option  : define ECC_ERR_LOG_SCRUB_EN to add a scrub (write-back) request
//           channel for corrected single-bit errors.
// ---------------------------------------------------------------------------
module ecc_err_log #(
    parameter int ADDR_W  = 32,
    parameter int SYN_W   = 5,
    parameter int CNT_W   = 16,
    parameter int LATENCY = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ecc_err_log_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } irqState_e;

    logic              w_vA;
    logic [ADDR_W-1:0] w_aA;

    // Valid/address alignment: a shift register of LATENCY stages that only
    // moves on enabled cycles, so it tracks the decoder pipeline exactly.
    generate
        if (LATENCY == 0) begin : g_noDelay
            assign w_vA = bus.rd_valid_i;
            assign w_aA = bus.rd_addr_i;
        end else begin : g_delay
            logic [LATENCY-1:0] r_vPipe;
            logic [ADDR_W-1:0]  r_aPipe [LATENCY];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_vPipe <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        r_aPipe[i] <= '0;
                    end
                end else if (bus.clkena_i) begin
                    r_vPipe[0] <= bus.rd_valid_i;
                    r_aPipe[0] <= bus.rd_addr_i;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_vPipe[i] <= r_vPipe[i-1];
                        r_aPipe[i] <= r_aPipe[i-1];
                    end
                end
            end

            assign w_vA = r_vPipe[LATENCY-1];
            assign w_aA = r_aPipe[LATENCY-1];
        end
    endgenerate

    // Double-bit wins if the decoder flags both.
    logic w_evDb;
    logic w_evSb;
    assign w_evDb = w_vA & bus.db_err_i;
    assign w_evSb = w_vA & bus.sb_err_i & ~bus.db_err_i;

    logic [CNT_W-1:0]  r_sbCnt;
    logic [CNT_W-1:0]  r_dbCnt;
    logic              r_sbVld;
    logic              r_dbVld;
    logic [ADDR_W-1:0] r_sbAddr;
    logic [ADDR_W-1:0] r_dbAddr;
    logic [SYN_W-1:0]  r_sbSyn;
    logic [SYN_W-1:0]  r_dbSyn;

    // A clear in the same cycle as an event must behave as if the clear
    // happened first, so every update is computed from the post-clear view.
    logic [CNT_W-1:0] w_sbBase;
    logic [CNT_W-1:0] w_dbBase;
    logic [CNT_W-1:0] w_sbInc;
    logic [CNT_W-1:0] w_sbNext;
    logic [CNT_W-1:0] w_dbNext;
    logic             w_sbSat;
    logic             w_dbSat;
    logic             w_sbVldBase;
    logic             w_dbVldBase;
    logic             w_sbCap;
    logic             w_dbCap;

    assign w_sbBase    = bus.clr_i ? '0 : r_sbCnt;
    assign w_dbBase    = bus.clr_i ? '0 : r_dbCnt;
    assign w_sbSat     = &w_sbBase;
    assign w_dbSat     = &w_dbBase;
    assign w_sbInc     = w_sbBase + CNT_W'(1);
    assign w_sbNext    = (w_evSb && !w_sbSat) ? w_sbInc : w_sbBase;
    assign w_dbNext    = (w_evDb && !w_dbSat) ? (w_dbBase + CNT_W'(1)) : w_dbBase;
    assign w_sbVldBase = bus.clr_i ? 1'b0 : r_sbVld;
    assign w_dbVldBase = bus.clr_i ? 1'b0 : r_dbVld;
    assign w_sbCap     = w_evSb & ~w_sbVldBase;
    assign w_dbCap     = w_evDb & ~w_dbVldBase;

    // Counters and first-error captures; nothing moves on a disabled cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sbCnt  <= '0;
            r_dbCnt  <= '0;
            r_sbVld  <= 1'b0;
            r_dbVld  <= 1'b0;
            r_sbAddr <= '0;
            r_dbAddr <= '0;
            r_sbSyn  <= '0;
            r_dbSyn  <= '0;
        end else if (bus.clkena_i) begin
            r_sbCnt <= w_sbNext;
            r_dbCnt <= w_dbNext;
            r_sbVld <= w_sbVldBase | w_evSb;
            r_dbVld <= w_dbVldBase | w_evDb;
            if (w_sbCap) begin
                r_sbAddr <= w_aA;
                r_sbSyn  <= bus.syndrome_i;
            end else if (bus.clr_i) begin
                r_sbAddr <= '0;
                r_sbSyn  <= '0;
            end
            if (w_dbCap) begin
                r_dbAddr <= w_aA;
                r_dbSyn  <= bus.syndrome_i;
            end else if (bus.clr_i) begin
                r_dbAddr <= '0;
                r_dbSyn  <= '0;
            end
        end
    end

    // The SB trigger requires a real increment, so an all-ones threshold
    // fires once on reaching saturation and never again while it holds.
    logic w_sbTrig;
    logic w_trig;
    assign w_sbTrig = w_evSb && !w_sbSat && (w_sbInc == bus.thresh_i)
                      && (bus.thresh_i != '0);
    assign w_trig   = w_evDb | w_sbTrig;

    irqState_e r_state;
    irqState_e w_stateBase;
    irqState_e w_stateNext;
    logic      w_irq;

    // Interrupt FSM: state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else if (bus.clkena_i) begin
            r_state <= w_stateNext;
        end
    end

    // Interrupt FSM: next state. Clear drops to IDLE before the trigger is
    // considered; a trigger in the ack cycle keeps the interrupt pending.
    always_comb begin
        w_stateBase = bus.clr_i ? IDLE : r_state;
        w_stateNext = w_stateBase;
        case (w_stateBase)
            IDLE: if (w_trig) w_stateNext = PEND;
            PEND: if (bus.irq_ack_i && !w_trig) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Interrupt FSM: output.
    always_comb begin
        w_irq = (r_state == PEND);
    end

    assign bus.sb_cnt_o  = r_sbCnt;
    assign bus.db_cnt_o  = r_dbCnt;
    assign bus.sb_vld_o  = r_sbVld;
    assign bus.db_vld_o  = r_dbVld;
    assign bus.sb_addr_o = r_sbAddr;
    assign bus.db_addr_o = r_dbAddr;
    assign bus.sb_syn_o  = r_sbSyn;
    assign bus.db_syn_o  = r_dbSyn;
    assign bus.irq_o     = w_irq;

`ifdef ECC_ERR_LOG_SCRUB_EN
    logic              r_scrubReq;
    logic [ADDR_W-1:0] r_scrubAddr;
    logic              w_scrubPend;

    assign w_scrubPend = bus.clr_i ? 1'b0 : r_scrubReq;

    // Scrub request: one outstanding at a time. While pending (including the
    // ack cycle) new corrected events are dropped; the address stays stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scrubReq  <= 1'b0;
            r_scrubAddr <= '0;
        end else if (bus.clkena_i) begin
            if (!w_scrubPend && w_evSb && bus.sb_fix_i) begin
                r_scrubReq  <= 1'b1;
                r_scrubAddr <= w_aA;
            end else if (w_scrubPend && bus.scrub_ack_i) begin
                r_scrubReq <= 1'b0;
            end else begin
                r_scrubReq <= w_scrubPend;
            end
        end
    end

    assign bus.scrub_req_o  = r_scrubReq;
    assign bus.scrub_addr_o = r_scrubAddr;
`else
    // The fix flag only matters for scrubbing.
    logic w_unusedFix;
    assign w_unusedFix = bus.sb_fix_i;
`endif

endmodule
